// File: rtl/gpio_input_conditioner.sv
// Conditions raw pad inputs: per-channel synchroniser, counter debounce and
// one-cycle rise/fall pulses, plus a registered any-event flag.

module gpio_ch_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];
    // Combinational view of "level flips on this edge"; lets the top register
    // event_any in the same cycle the pulses appear.
    assign accept = en && (s != level) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en || (s == level)) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module gpio_input_conditioner #(
    parameter int N_CH            = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] pin_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            event_any
);
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
            $error("DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic [N_CH-1:0] accept;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gpio_ch_cond #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .pin   (pin_in[i]),
            .level (level_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i]),
            .accept(accept[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) event_any <= 1'b0;
        else     event_any <= |accept;
    end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench: stimulus pushes expected events (cycle, level, pulses) into a
// scoreboard; a monitor pops and compares whenever the DUT shows an event.

module tb_gpio_input_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pin_in;
    logic [7:0] level_out, rise_pulse, fall_pulse;
    logic       event_any;

    typedef struct {
        int         cyc;
        logic [7:0] lvl;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    gpio_input_conditioner #(
        .N_CH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pin_in    (pin_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .event_any (event_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Expected event lands on edge (now + latency); the monitor sees it at that cycle's negedge.
    task automatic expect_ev(input int lat, input logic [7:0] l, input logic [7:0] r,
                             input logic [7:0] f);
        exp_t e;
        e.cyc = cyc + lat; e.lvl = l; e.rise = r; e.fall = f;
        sb.push_back(e);
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {8'h0, level_out, rise_pulse, fall_pulse} | {31'h0, event_any}, 32'h0);
    endtask

    always @(negedge clk) begin
        if ((event_any | (|rise_pulse) | (|fall_pulse)) === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: cyc %0d level %h rise %h fall %h ev %b",
                         cyc, level_out, rise_pulse, fall_pulse, event_any);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc == e.cyc && level_out === e.lvl && rise_pulse === e.rise &&
                    fall_pulse === e.fall && event_any === 1'b1)
                    passes++;
                else
                    $display("FAIL event: got cyc %0d lvl %h rise %h fall %h ev %b, expected cyc %0d lvl %h rise %h fall %h ev 1",
                             cyc, level_out, rise_pulse, fall_pulse, event_any,
                             e.cyc, e.lvl, e.rise, e.fall);
            end
        end
    end

    initial begin
        // 1: reset with all pins high
        rst = 1'b1; en = 1'b1; pin_in = 8'hFF;
        tick(1); chk_quiet("reset_edge1");
        tick(1); chk_quiet("reset_edge2");
        rst = 1'b0; pin_in = 8'h00;
        tick(1); chk_quiet("after_reset");

        // 2: single rise on ch0, 18-edge latency
        pin_in[0] = 1'b1; expect_ev(18, 8'h01, 8'h01, 8'h00);
        tick(25); chk("level_t2", level_out, 8'h01);

        // 3: bouncing ch3, then held high
        for (int k = 0; k < 8; k++) begin
            pin_in[3] = (k % 2 == 0);
            tick(5);
        end
        pin_in[3] = 1'b1; expect_ev(18, 8'h09, 8'h08, 8'h00);
        tick(25); chk("level_t3", level_out, 8'h09);
        // 15-cycle glitch is one comparison short of acceptance
        pin_in[5] = 1'b1; tick(15); pin_in[5] = 1'b0;
        tick(25); chk("level_glitch", level_out, 8'h09);

        // 4: simultaneous events on ch0 and ch7
        pin_in[0] = 1'b0; pin_in[7] = 1'b1; expect_ev(18, 8'h88, 8'h80, 8'h01);
        tick(25); chk("level_t4a", level_out, 8'h88);
        pin_in[0] = 1'b1; pin_in[7] = 1'b0; expect_ev(18, 8'h09, 8'h01, 8'h80);
        tick(25); chk("level_t4b", level_out, 8'h09);

        // 5: en dropped at edges 10..14; change needs 16 fresh enabled edges
        pin_in[2] = 1'b1; expect_ev(30, 8'h0D, 8'h04, 8'h00);
        tick(9); en = 1'b0;
        tick(5); chk("level_en_low", level_out, 8'h09);
        en = 1'b1;
        tick(25); chk("level_t5", level_out, 8'h0D);

        // 6: reset at edge 12 of pending ch1 change; all high pins re-accepted
        pin_in[1] = 1'b1;
        tick(11); rst = 1'b1;
        tick(1); chk_quiet("midcount_reset");
        rst = 1'b0; expect_ev(18, 8'h0F, 8'h0F, 8'h00);
        tick(25); chk("level_t6", level_out, 8'h0F);

        tick(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
